// File: rtl/rfg_axis_protocol_arbiter.sv
// Frame-aware round-robin arbiter in front of the register-file protocol parser.
// A grant is held for one complete frame. The forwarded stream is tagged with the source port on tid.
module rfg_axis_protocol_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic [3:0]                      grant_port,
  output logic                            busy,
  output logic                            frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_ADDRESS = 3'd2,
    ST_LENA    = 3'd3,
    ST_LENB    = 3'd4,
    ST_PAYLOAD = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_grant;
  logic [3:0]              r_last_grant;
  logic [ID_WIDTH-1:0]     r_tid;
  logic [DATA_WIDTH-1:0]   r_hdr;
  logic [DATA_WIDTH-1:0]   r_len_lo;
  logic [15:0]             r_count;
  logic                    r_busy;
  logic                    r_frame_done;

  logic [2*NUM_PORTS-1:0]  w_req2;
  logic [2*NUM_PORTS-1:0]  w_rot;
  logic [4:0]              w_off;
  logic [4:0]              w_sum;
  logic [3:0]              w_pick;
  logic                    w_any_req;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_sel_valid;
  logic                    w_active;
  logic                    w_beat;
  logic                    w_to_idle;

  // Round-robin pick: rotate the requests so the port after last_grant sits at bit 0
  always_comb begin
    w_req2    = {s_axis_tvalid, s_axis_tvalid};
    w_rot     = w_req2 >> ({1'b0, r_last_grant} + 5'd1);
    w_off     = 5'd0;
    w_any_req = 1'b0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off     = 5'(j);
        w_any_req = 1'b1;
      end else begin
        w_off     = w_off;
      end
    end
    w_sum = {1'b0, r_last_grant} + 5'd1 + w_off;
    if (w_sum >= 5'(NUM_PORTS)) begin
      w_sum = w_sum - 5'(NUM_PORTS);
    end else begin
      w_sum = w_sum;
    end
    w_pick = w_sum[3:0];
  end

  // Select the granted source lane
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == 4'(i)) begin
        w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid = s_axis_tvalid[i];
      end else begin
        w_sel_data  = w_sel_data;
        w_sel_valid = w_sel_valid;
      end
    end
  end

  // Output process: pass-through is live only while a frame is in progress
  always_comb begin
    w_active      = (r_state != ST_IDLE);
    m_axis_tvalid = w_active & w_sel_valid;
    m_axis_tdata  = w_active ? w_sel_data : '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_active && (r_grant == 4'(i))) begin
        s_axis_tready[i] = m_axis_tready;
      end else begin
        s_axis_tready[i] = 1'b0;
      end
    end
    w_beat = m_axis_tvalid & m_axis_tready;
  end

  // Next-state process: frame parser
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_HEADER;
        else           w_state_nxt = ST_IDLE;
      end
      ST_HEADER: begin
        if (w_beat) w_state_nxt = (m_axis_tdata[0] | m_axis_tdata[1]) ? ST_ADDRESS : ST_IDLE;
        else        w_state_nxt = ST_HEADER;
      end
      ST_ADDRESS: begin
        if (w_beat) w_state_nxt = ST_LENA;
        else        w_state_nxt = ST_ADDRESS;
      end
      ST_LENA: begin
        if (w_beat) w_state_nxt = ST_LENB;
        else        w_state_nxt = ST_LENA;
      end
      ST_LENB: begin
        // Only writes carry payload; write wins when both bits are set
        if (w_beat) w_state_nxt = r_hdr[0] ? ST_PAYLOAD : ST_IDLE;
        else        w_state_nxt = ST_LENB;
      end
      ST_PAYLOAD: begin
        if (w_beat && (r_count == 16'd1)) w_state_nxt = ST_IDLE;
        else                              w_state_nxt = ST_PAYLOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
  end

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant, field capture, payload counter and status flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_grant      <= 4'd0;
      r_last_grant <= 4'(NUM_PORTS - 1);
      r_tid        <= '0;
      r_hdr        <= '0;
      r_len_lo     <= '0;
      r_count      <= 16'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_any_req) begin
        r_grant <= w_pick;
        r_tid   <= ID_WIDTH'(w_pick);
      end
      if (w_beat) begin
        case (r_state)
          ST_HEADER:  r_hdr    <= m_axis_tdata;
          ST_LENA:    r_len_lo <= m_axis_tdata;
          ST_LENB:    if (r_hdr[0]) r_count <= {m_axis_tdata, r_len_lo};
          // Length 0 wraps to 0xFFFF and runs for 65536 bytes
          ST_PAYLOAD: r_count  <= r_count - 16'd1;
          default:    r_count  <= r_count;
        endcase
      end
      if (w_to_idle) r_last_grant <= r_grant;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= w_to_idle;
    end
  end

  assign m_axis_tid = r_tid;
  assign grant_port = r_grant;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_rfg_axis_protocol_arbiter.sv
// Directed bench: per-cycle vector table plus source/sink sequences for multi-frame cases.
module tb_rfg_axis_protocol_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tid;
  logic [3:0]  grant_port;
  logic        busy;
  logic        frame_done;

  int n_pass = 0;
  int n_total = 0;

  always #5 aclk = ~aclk;

  rfg_axis_protocol_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .ID_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .grant_port(grant_port), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  tv;
    logic [31:0] td;
    logic [3:0]  sr;
    logic        mv;
    logic [7:0]  md;
    logic [7:0]  tid;
    logic [3:0]  gp;
    logic        bz;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] tv, input logic [31:0] td, input logic [3:0] sr,
                     input logic mv, input logic [7:0] md, input logic [7:0] tid, input logic [3:0] gp,
                     input logic bz, input logic fd);
    vec_t v;
    v.rst_n = r; v.tv = tv; v.td = td; v.sr = sr; v.mv = mv; v.md = md;
    v.tid = tid; v.gp = gp; v.bz = bz; v.fd = fd;
    vecs.push_back(v);
  endtask

  // Source / sink model for the multi-frame sequences
  logic [7:0] src_mem [4][32];
  int         src_len [4];
  int         src_pos [4];
  logic [7:0] exp_data [64];
  logic [7:0] exp_tid  [64];
  logic [7:0] mon_data [64];
  logic [7:0] mon_tid  [64];
  int         exp_n, mon_n, fd_cnt;

  task automatic clr();
    for (int p = 0; p < 4; p++) begin src_len[p] = 0; src_pos[p] = 0; end
    exp_n = 0; mon_n = 0; fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin mon_data[i] = 8'hxx; mon_tid[i] = 8'hxx; end
  endtask

  task automatic push_frame(input int p, input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      src_mem[p][src_len[p]] = b[63-8*k -: 8];
      src_len[p]++;
    end
  endtask

  task automatic expect_frame(input logic [7:0] tid, input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      exp_data[exp_n] = b[63-8*k -: 8];
      exp_tid[exp_n]  = tid;
      exp_n++;
    end
  endtask

  task automatic do_reset();
    #1;
    aresetn = 1'b0; s_tvalid = 4'd0; s_tdata = 32'd0; m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic run_bfm(input string name, input int lo_start, input int lo_end, input int max_cyc);
    int  cyc;
    bit  done;
    bit  all_sent;
    logic [3:0] exp_sr;
    cyc = 0; done = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(posedge aclk); #1;
      for (int p = 0; p < 4; p++) begin
        s_tvalid[p]       = (src_pos[p] < src_len[p]);
        s_tdata[p*8 +: 8] = s_tvalid[p] ? src_mem[p][src_pos[p]] : 8'h00;
      end
      m_tready = !((cyc >= lo_start) && (cyc <= lo_end));
      @(negedge aclk);
      exp_sr = busy ? (4'({3'b000, m_tready}) << grant_port) : 4'd0;
      chk($sformatf("%s_c%0d_sready", name, cyc), {28'd0, s_tready}, {28'd0, exp_sr});
      chk($sformatf("%s_c%0d_mvalid", name, cyc), {31'd0, m_tvalid},
          {31'd0, busy & s_tvalid[grant_port]});
      if (m_tvalid && m_tready && mon_n < 64) begin
        mon_data[mon_n] = m_tdata;
        mon_tid[mon_n]  = m_tid;
        mon_n++;
      end
      if (frame_done) fd_cnt++;
      all_sent = 1'b1;
      for (int p = 0; p < 4; p++) begin
        if (s_tready[p] && s_tvalid[p]) src_pos[p]++;
        if (src_pos[p] < src_len[p]) all_sent = 1'b0;
      end
      if (all_sent && !busy) done = 1'b1;
      cyc++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d cycles without completion, required done within %0d", name, cyc, max_cyc);
    end
    s_tvalid = 4'd0; m_tready = 1'b1;
  endtask

  task automatic check_stream(input string name, input int exp_fd);
    chk($sformatf("%s_count", name), 32'(mon_n), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      chk($sformatf("%s_b%0d_data", name, i), {24'd0, mon_data[i]}, {24'd0, exp_data[i]});
      chk($sformatf("%s_b%0d_tid", name, i), {24'd0, mon_tid[i]}, {24'd0, exp_tid[i]});
    end
    chk($sformatf("%s_frame_done", name), 32'(fd_cnt), 32'(exp_fd));
  endtask

  initial begin
    aresetn = 1'b0; s_tvalid = 4'd0; s_tdata = 32'd0; m_tready = 1'b1;
    repeat (3) @(posedge aclk);

    // rst  tv     tdata          sready mv  md     tid    gp    busy fd
    add(1'b0, 4'h1, 32'h0000_0001, 4'h0, 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0);
    // Port 1 write frame 01 10 02 00 AA BB
    add(1'b1, 4'h2, 32'h0000_0100, 4'h0, 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 4'h2, 32'h0000_0100, 4'h2, 1'b1, 8'h01, 8'd1, 4'd1, 1'b1, 1'b0);
    add(1'b1, 4'h2, 32'h0000_1000, 4'h2, 1'b1, 8'h10, 8'd1, 4'd1, 1'b1, 1'b0);
    add(1'b1, 4'h2, 32'h0000_0200, 4'h2, 1'b1, 8'h02, 8'd1, 4'd1, 1'b1, 1'b0);
    add(1'b1, 4'h2, 32'h0000_0000, 4'h2, 1'b1, 8'h00, 8'd1, 4'd1, 1'b1, 1'b0);
    add(1'b1, 4'h2, 32'h0000_AA00, 4'h2, 1'b1, 8'hAA, 8'd1, 4'd1, 1'b1, 1'b0);
    add(1'b1, 4'h2, 32'h0000_BB00, 4'h2, 1'b1, 8'hBB, 8'd1, 4'd1, 1'b1, 1'b0);
    add(1'b1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 8'd1, 4'd1, 1'b0, 1'b1);
    add(1'b1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 8'd1, 4'd1, 1'b0, 1'b0);
    // Port 0 read frame 02 20 04 00, port 2 pending
    add(1'b1, 4'h1, 32'h0000_0002, 4'h0, 1'b0, 8'h00, 8'd1, 4'd1, 1'b0, 1'b0);
    add(1'b1, 4'h5, 32'h0077_0002, 4'h1, 1'b1, 8'h02, 8'd0, 4'd0, 1'b1, 1'b0);
    add(1'b1, 4'h5, 32'h0077_0020, 4'h1, 1'b1, 8'h20, 8'd0, 4'd0, 1'b1, 1'b0);
    add(1'b1, 4'h5, 32'h0077_0004, 4'h1, 1'b1, 8'h04, 8'd0, 4'd0, 1'b1, 1'b0);
    add(1'b1, 4'h5, 32'h0077_0000, 4'h1, 1'b1, 8'h00, 8'd0, 4'd0, 1'b1, 1'b0);
    add(1'b1, 4'h4, 32'h0001_0000, 4'h0, 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b1);
    add(1'b1, 4'h4, 32'h0001_0000, 4'h4, 1'b1, 8'h01, 8'd2, 4'd2, 1'b1, 1'b0);
    add(1'b1, 4'h4, 32'h0030_0000, 4'h4, 1'b1, 8'h30, 8'd2, 4'd2, 1'b1, 1'b0);
    add(1'b1, 4'h4, 32'h0001_0000, 4'h4, 1'b1, 8'h01, 8'd2, 4'd2, 1'b1, 1'b0);
    add(1'b1, 4'h4, 32'h0000_0000, 4'h4, 1'b1, 8'h00, 8'd2, 4'd2, 1'b1, 1'b0);
    add(1'b1, 4'h4, 32'h00CC_0000, 4'h4, 1'b1, 8'hCC, 8'd2, 4'd2, 1'b1, 1'b0);
    add(1'b1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 8'd2, 4'd2, 1'b0, 1'b1);
    // Port 3 write, reset lands in PAYLOAD with 3 bytes left
    add(1'b1, 4'h8, 32'h0100_0000, 4'h0, 1'b0, 8'h00, 8'd2, 4'd2, 1'b0, 1'b0);
    add(1'b1, 4'h8, 32'h0100_0000, 4'h8, 1'b1, 8'h01, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b1, 4'h8, 32'h4000_0000, 4'h8, 1'b1, 8'h40, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b1, 4'h8, 32'h0500_0000, 4'h8, 1'b1, 8'h05, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b1, 4'h8, 32'h0000_0000, 4'h8, 1'b1, 8'h00, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b1, 4'h8, 32'hE100_0000, 4'h8, 1'b1, 8'hE1, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b1, 4'h8, 32'hE200_0000, 4'h8, 1'b1, 8'hE2, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b0, 4'h8, 32'hE300_0000, 4'h8, 1'b1, 8'hE3, 8'd3, 4'd3, 1'b1, 1'b0);
    add(1'b1, 4'h9, 32'hE300_0001, 4'h0, 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 4'h9, 32'hE300_0001, 4'h1, 1'b1, 8'h01, 8'd0, 4'd0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      #1;
      aresetn = vecs[i].rst_n; s_tvalid = vecs[i].tv; s_tdata = vecs[i].td; m_tready = 1'b1;
      @(negedge aclk);
      chk($sformatf("row%0d_sready", i), {28'd0, s_tready}, {28'd0, vecs[i].sr});
      chk($sformatf("row%0d_mvalid", i), {31'd0, m_tvalid}, {31'd0, vecs[i].mv});
      if (vecs[i].mv) chk($sformatf("row%0d_mdata", i), {24'd0, m_tdata}, {24'd0, vecs[i].md});
      chk($sformatf("row%0d_tid", i), {24'd0, m_tid}, {24'd0, vecs[i].tid});
      chk($sformatf("row%0d_grant", i), {28'd0, grant_port}, {28'd0, vecs[i].gp});
      chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bz});
      chk($sformatf("row%0d_fdone", i), {31'd0, frame_done}, {31'd0, vecs[i].fd});
      @(posedge aclk);
    end

    // Ports 0 and 2 both busy from reset: grants alternate 0,2,0,2
    do_reset();
    clr();
    push_frame(0, 64'h01A0_0100_1100_0000, 5);
    push_frame(0, 64'h01A1_0100_1200_0000, 5);
    push_frame(2, 64'h01B0_0100_2100_0000, 5);
    push_frame(2, 64'h01B1_0100_2200_0000, 5);
    expect_frame(8'd0, 64'h01A0_0100_1100_0000, 5);
    expect_frame(8'd2, 64'h01B0_0100_2100_0000, 5);
    expect_frame(8'd0, 64'h01A1_0100_1200_0000, 5);
    expect_frame(8'd2, 64'h01B1_0100_2200_0000, 5);
    run_bfm("alt", -1, -1, 200);
    check_stream("alt", 4);

    // Port 3 payload stalled by the sink for 5 cycles
    clr();
    push_frame(3, 64'h01C0_0400_D1D2_D3D4, 8);
    expect_frame(8'd3, 64'h01C0_0400_D1D2_D3D4, 8);
    run_bfm("stall", 7, 11, 200);
    check_stream("stall", 1);

    // Invalid header releases the grant, next frame re-arbitrated intact
    clr();
    push_frame(1, 64'h0000_0000_0000_0000, 1);
    push_frame(1, 64'h0100_0100_5500_0000, 5);
    expect_frame(8'd1, 64'h0000_0000_0000_0000, 1);
    expect_frame(8'd1, 64'h0100_0100_5500_0000, 5);
    run_bfm("badhdr", -1, -1, 200);
    check_stream("badhdr", 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
